serial_alu_ctrl: RTL and testbench

- Bit-serial sequencer that computes a WIDTH-bit ALU operation on a single shared 1-bit ALU_SLICE.
- Feeds the slice one bit per clock, LSB first, and holds the carry in a flop between bits.
- Assembles the result and produces carryout, overflow and zero flags.
- Sits between the CPU/bench issue logic (valid/ready request in, done pulse out) and one external ALU_SLICE instance.

---
 rtl/serial_alu_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_alu_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice LSB first,
// holds the inter-bit carry in a flop, then derives flags and the SLT result.
`ifndef ADD_
`define ADD_  3'd0
`define SUB_  3'd1
`define XOR_  3'd2
`define SLT_  3'd3
`define AND_  3'd4
`define NAND_ 3'd5
`define NOR_  3'd6
`define OR_   3'd7
`endif

module serial_alu_ctrl #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ctrl_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic [2:0]       slice_ctrl,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    input  logic             slice_r,
    input  logic             slice_cout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    state_t           state, state_next;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic             cin_msb, cout_msb;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             lt;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        slice_ctrl = op;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_cin  = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                slice_a   = a_reg[idx];
                slice_b   = b_reg[idx];
                slice_cin = carry;
                // SLT is a subtract on the slice; the sign test happens in FIN
                if (op == `SLT_) slice_ctrl = `SUB_;
                if (idx == LAST) state_next = S_FIN;
            end
            S_FIN:   state_next = S_DONE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign lt   = result[WIDTH-1] ^ (cin_msb ^ cout_msb);
    assign zero = (result == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            cout_msb <= 1'b0;
            op       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        op       <= ctrl_in;
                        idx      <= '0;
                        carry    <= (ctrl_in == `SUB_) || (ctrl_in == `SLT_);
                        result   <= '0;
                        carryout <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    result[idx] <= slice_r;
                    carry       <= slice_cout;
                    idx         <= idx + 1'b1;
                    if (idx == LAST) begin
                        cin_msb  <= carry;
                        cout_msb <= slice_cout;
                    end
                end
                S_FIN: begin
                    case (op)
                        `ADD_, `SUB_: begin
                            carryout <= cout_msb;
                            overflow <= cin_msb ^ cout_msb;
                        end
                        `SLT_:   result <= {{(WIDTH-1){1'b0}}, lt};
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl at WIDTH=8 with a behavioural 1-bit
// slice (5 ns combinational delay) closing the loop.
`timescale 1ns/1ps
`ifndef ADD_
`define ADD_  3'd0
`define SUB_  3'd1
`define XOR_  3'd2
`define SLT_  3'd3
`define AND_  3'd4
`define NAND_ 3'd5
`define NOR_  3'd6
`define OR_   3'd7
`endif

module tb_serial_alu_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   ctrl_in;
    logic [W-1:0] a_in, b_in;
    logic         ready, done, carryout, overflow, zero;
    logic [W-1:0] result;
    logic [2:0]   slice_ctrl;
    logic         slice_a, slice_b, slice_cin, slice_r, slice_cout;
    logic [1:0]   slice_out;

    int tests_run    = 0;
    int tests_failed = 0;
    exp_t expq[$];

    always #10 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ctrl_in(ctrl_in),
        .a_in(a_in), .b_in(b_in), .ready(ready), .done(done),
        .result(result), .carryout(carryout), .overflow(overflow), .zero(zero),
        .slice_ctrl(slice_ctrl), .slice_a(slice_a), .slice_b(slice_b),
        .slice_cin(slice_cin), .slice_r(slice_r), .slice_cout(slice_cout)
    );

    function automatic logic [1:0] slice_fn(input logic [2:0] c, input logic a, b, cin);
        logic bb;
        bb = (c == `SUB_ || c == `SLT_) ? ~b : b;
        case (c)
            `ADD_, `SUB_, `SLT_: return {(a & bb) | (a & cin) | (bb & cin), a ^ bb ^ cin};
            `XOR_:  return {1'b0, a ^ b};
            `AND_:  return {1'b0, a & b};
            `NAND_: return {1'b0, ~(a & b)};
            `NOR_:  return {1'b0, ~(a | b)};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign #5 slice_out = slice_fn(slice_ctrl, slice_a, slice_b, slice_cin);
    assign slice_r    = slice_out[0];
    assign slice_cout = slice_out[1];

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b);
        logic [W:0] s;
        exp_t e;
        e = '0;
        case (op)
            `ADD_: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0]; e.co = s[W];
                e.ov = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            `SUB_: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                e.res = s[W-1:0]; e.co = s[W];
                e.ov = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            `SLT_:  e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            `XOR_:  e.res = a ^ b;
            `AND_:  e.res = a & b;
            `NAND_: e.res = ~(a & b);
            `NOR_:  e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic co, ov, z);
        exp_t e;
        e.res = r; e.co = co; e.ov = ov; e.z = z;
        return e;
    endfunction

    // Leaves the bench at the negedge of RUN cycle 1 (start already dropped).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b);
        @(negedge clk);
        ctrl_in = op; a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat is the cycle number (accept edge starts cycle 1) at which done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; ctrl_in = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ready, done, result, carryout, overflow, zero} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b done=%b res=%h co=%b ov=%b z=%b want rdy=1 done=0 res=00 co=0 ov=0 z=1",
                     ready, done, result, carryout, overflow, zero);
        end
        tests_run++;
        if ({slice_a, slice_b, slice_cin} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_slice: got a/b/cin=%b%b%b want 000", slice_a, slice_b, slice_cin);
        end
        reset = 1'b0;
    endtask

    task automatic test_add;
        int lat;
        exp_t e;
        issue(`ADD_, 8'h7F, 8'h01);
        expq.push_back(mk(8'h80, 1'b0, 1'b1, 1'b0));
        wait_done(lat);
        e = expq.pop_front();
        tests_run++;
        if (lat != 10) begin
            tests_failed++;
            $display("FAIL add_latency: got done in cycle %0d want 10", lat);
        end
        tests_run++;
        if ({result, carryout, overflow, zero} !== e) begin
            tests_failed++;
            $display("FAIL add_7f_01: got res=%h co=%b ov=%b z=%b want %h %b %b %b",
                     result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || result !== e.res) begin
            tests_failed++;
            $display("FAIL add_done_width: got done=%b res=%h after pulse want done=0 res=%h", done, result, e.res);
        end
    endtask

    task automatic test_sub;
        int lat;
        exp_t e;
        logic [W-1:0] as [2] = '{8'h05, 8'h80};
        logic [W-1:0] bs [2] = '{8'h05, 8'h01};
        exp_t want [2];
        want[0] = mk(8'h00, 1'b1, 1'b0, 1'b1);
        want[1] = mk(8'h7F, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            issue(`SUB_, as[i], bs[i]);
            expq.push_back(want[i]);
            wait_done(lat);
            e = expq.pop_front();
            tests_run++;
            if (done !== 1'b1 || {result, carryout, overflow, zero} !== e) begin
                tests_failed++;
                $display("FAIL sub_%0d: got done=%b res=%h co=%b ov=%b z=%b want done=1 %h %b %b %b",
                         i, done, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
            end
        end
    endtask

    task automatic test_slt;
        int lat;
        exp_t e;
        logic [W-1:0] as [3] = '{8'h80, 8'h01, 8'h03};
        logic [W-1:0] bs [3] = '{8'h01, 8'hFF, 8'h03};
        logic [W-1:0] rs [3] = '{8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            issue(`SLT_, as[i], bs[i]);
            expq.push_back(mk(rs[i], 1'b0, 1'b0, rs[i] == '0));
            if (i == 0) begin
                tests_run++;
                if (slice_ctrl !== `SUB_) begin
                    tests_failed++;
                    $display("FAIL slt_slice_ctrl: got %0d want %0d", slice_ctrl, `SUB_);
                end
            end
            wait_done(lat);
            e = expq.pop_front();
            tests_run++;
            if (done !== 1'b1 || {result, carryout, overflow, zero} !== e) begin
                tests_failed++;
                $display("FAIL slt_%0d: got done=%b res=%h co=%b ov=%b z=%b want done=1 %h %b %b %b",
                         i, done, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
            end
        end
    endtask

    task automatic test_logic;
        int lat;
        exp_t e;
        logic [2:0]   ops  [5] = '{`XOR_, `AND_, `OR_, `NAND_, `NOR_};
        logic [W-1:0] want [5] = '{8'h96, 8'h48, 8'hDE, 8'hB7, 8'h21};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], 8'hCA, 8'h5C);
            expq.push_back(mk(want[i], 1'b0, 1'b0, 1'b0));
            wait_done(lat);
            e = expq.pop_front();
            tests_run++;
            if (done !== 1'b1 || {result, carryout, overflow, zero} !== e) begin
                tests_failed++;
                $display("FAIL logic_op%0d: got done=%b res=%h co=%b ov=%b z=%b want done=1 %h %b %b %b",
                         ops[i], done, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        exp_t e;
        bit ready_seen;
        @(negedge clk);
        ctrl_in = `AND_; a_in = 8'hFF; b_in = 8'h0F; start = 1'b1;
        expq.push_back(mk(8'h0F, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        ctrl_in = `ADD_; a_in = 8'h01; b_in = 8'h01;
        ready_seen = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (ready === 1'b1) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        e = expq.pop_front();
        tests_run++;
        if (ready_seen || lat != 10) begin
            tests_failed++;
            $display("FAIL b2b_busy: got ready_seen=%b done_cycle=%0d want ready_seen=0 done_cycle=10", ready_seen, lat);
        end
        tests_run++;
        if (done !== 1'b1 || result !== e.res) begin
            tests_failed++;
            $display("FAIL b2b_first: got done=%b res=%h want done=1 res=%h", done, result, e.res);
        end
        @(negedge clk);
        expq.push_back(mk(8'h02, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        e = expq.pop_front();
        tests_run++;
        if (done !== 1'b1 || lat != 10 || {result, carryout, overflow, zero} !== e) begin
            tests_failed++;
            $display("FAIL b2b_second: got done=%b cycle=%0d res=%h co=%b ov=%b want done=1 cycle=10 res=%h co=%b ov=%b",
                     done, lat, result, carryout, overflow, e.res, e.co, e.ov);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        exp_t e;
        bit done_seen;
        issue(`ADD_, 8'hFF, 8'h01);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== 8'h00 || slice_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got rdy=%b done=%b res=%h cin=%b want rdy=1 done=0 res=00 cin=0",
                     ready, done, result, slice_cin);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
        end
        tests_run++;
        if (done_seen) begin
            tests_failed++;
            $display("FAIL reset_no_done: got done pulse after abort want none");
        end
        issue(`ADD_, 8'h01, 8'h02);
        expq.push_back(mk(8'h03, 1'b0, 1'b0, 1'b0));
        wait_done(lat);
        e = expq.pop_front();
        tests_run++;
        if (done !== 1'b1 || lat != 10 || {result, carryout, overflow, zero} !== e) begin
            tests_failed++;
            $display("FAIL reset_recover: got done=%b cycle=%0d res=%h want done=1 cycle=10 res=%h", done, lat, result, e.res);
        end
    endtask

    task automatic test_random;
        int lat;
        exp_t e;
        logic [2:0] op;
        logic [W-1:0] a, b;
        logic [2:0] ops [8] = '{`ADD_, `SUB_, `XOR_, `SLT_, `AND_, `NAND_, `NOR_, `OR_};
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = W'($urandom);
            b  = W'($urandom);
            issue(op, a, b);
            expq.push_back(model(op, a, b));
            wait_done(lat);
            e = expq.pop_front();
            tests_run++;
            if (done !== 1'b1 || {result, carryout, overflow, zero} !== e) begin
                tests_failed++;
                $display("FAIL rand_op%0d_%h_%h: got done=%b res=%h co=%b ov=%b z=%b want done=1 %h %b %b %b",
                         op, a, b, done, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
